// File: rtl/mem_port_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cpu_bus_pkg
// Purpose  : Shared types and constants for the CPU memory-port arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package cpu_bus_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } arb_state_t;

  typedef logic req_id_t;

  localparam req_id_t REQ_FETCH = 1'b0;
  localparam req_id_t REQ_DATA  = 1'b1;

  function automatic logic [1:0] id_onehot(input req_id_t id);
    return (id == REQ_DATA) ? 2'b10 : 2'b01;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_port_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter_if
// Purpose  : Requester, response and memory-port signals of the arbiter.
// Revision : 1.0 - initial release
// ============================================================================
interface mem_port_arbiter_if
  import cpu_bus_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) ();

  logic              req0_valid;
  logic [ADDR_W-1:0] req0_addr;
  logic [DATA_W-1:0] req0_wdata;
  logic              req0_we;
  logic              req0_ready;
  logic              rsp0_valid;
  logic [DATA_W-1:0] rsp0_rdata;
  logic              rsp0_err;

  logic              req1_valid;
  logic [ADDR_W-1:0] req1_addr;
  logic [DATA_W-1:0] req1_wdata;
  logic              req1_we;
  logic              req1_ready;
  logic              rsp1_valid;
  logic [DATA_W-1:0] rsp1_rdata;
  logic              rsp1_err;

  logic              mem_valid;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_we;
  logic              mem_ready;
  logic              mem_rvalid;
  logic [DATA_W-1:0] mem_rdata;

  req_id_t           owner;

  // Arbiter side: owns the memory port and the response paths.
  modport master (
    input  req0_valid, req0_addr, req0_wdata, req0_we,
    input  req1_valid, req1_addr, req1_wdata, req1_we,
    input  mem_ready, mem_rvalid, mem_rdata,
    output req0_ready, rsp0_valid, rsp0_rdata, rsp0_err,
    output req1_ready, rsp1_valid, rsp1_rdata, rsp1_err,
    output mem_valid, mem_addr, mem_wdata, mem_we,
    output owner
  );

  modport slave (
    output req0_valid, req0_addr, req0_wdata, req0_we,
    output req1_valid, req1_addr, req1_wdata, req1_we,
    output mem_ready, mem_rvalid, mem_rdata,
    input  req0_ready, rsp0_valid, rsp0_rdata, rsp0_err,
    input  req1_ready, rsp1_valid, rsp1_rdata, rsp1_err,
    input  mem_valid, mem_addr, mem_wdata, mem_we,
    input  owner
  );

endinterface
`default_nettype wire

// File: rtl/mem_port_arbiter_rr_arbiter2.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter2
// Purpose  : Two-way round-robin pick; grant is one-hot, or zero when idle.
// Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter2
  import cpu_bus_pkg::*;
(
  input  logic [1:0] valid_i,
  input  req_id_t    rr_ptr_i,
  output logic [1:0] grant_o,
  output req_id_t    winner_o
);

  always_comb begin
    winner_o = REQ_FETCH;
    case (valid_i)
      2'b01:   winner_o = REQ_FETCH;
      2'b10:   winner_o = REQ_DATA;
      2'b11:   winner_o = rr_ptr_i;
      default: winner_o = REQ_FETCH;
    endcase
    grant_o = (valid_i == 2'b00) ? 2'b00 : id_onehot(winner_o);
  end

endmodule
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Purpose  : Shares one memory port between fetch and data requesters.
// Revision : 1.0 - initial release
// ============================================================================
module mem_port_arbiter
  import cpu_bus_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int TIMEOUT = 15
) (
  input  logic               clk,
  input  logic               rst,
  mem_port_arbiter_if.master bus
);

  localparam int               CNT_W    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  arb_state_t state_q, state_d;

  req_id_t    owner_q;
  req_id_t    rr_ptr_q;
  req_id_t    winner_w;

  logic [1:0] valid_w;
  logic [1:0] grant_w;
  logic [1:0] ready_w;
  logic       mem_valid_w;
  logic       accept_w;
  logic       handshake_w;
  logic       rsp_ok_w;
  logic       timeout_w;

  logic [CNT_W-1:0] cnt_q;

  logic [ADDR_W-1:0] mem_addr_q,  mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              mem_we_q,    mem_we_d;

  logic [1:0]             rsp_valid_q;
  logic [1:0]             rsp_err_q;
  logic [1:0][DATA_W-1:0] rsp_rdata_q;

  assign valid_w = {bus.req1_valid, bus.req0_valid};

  rr_arbiter2 u_rr_arbiter2 (
    .valid_i  (valid_w),
    .rr_ptr_i (rr_ptr_q),
    .grant_o  (grant_w),
    .winner_o (winner_w)
  );

  // 2:1 select path feeding the request latch.
  assign mem_addr_d  = (winner_w == REQ_DATA) ? bus.req1_addr  : bus.req0_addr;
  assign mem_wdata_d = (winner_w == REQ_DATA) ? bus.req1_wdata : bus.req0_wdata;
  assign mem_we_d    = (winner_w == REQ_DATA) ? bus.req1_we    : bus.req0_we;

  assign accept_w    = |(valid_w & ready_w);
  assign handshake_w = mem_valid_w & bus.mem_ready;
  assign rsp_ok_w    = (state_q == WAIT) & bus.mem_rvalid;
  // A response arriving on the last allowed cycle takes precedence.
  assign timeout_w   = (TIMEOUT != 0) && (state_q == WAIT) && !bus.mem_rvalid &&
                       (cnt_q == CNT_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept_w)               state_d = ISSUE;
      ISSUE:   if (handshake_w)            state_d = WAIT;
      WAIT:    if (rsp_ok_w || timeout_w)  state_d = IDLE;
      default:                             state_d = IDLE;
    endcase
  end

  always_comb begin
    ready_w     = 2'b00;
    mem_valid_w = 1'b0;
    case (state_q)
      IDLE:    ready_w     = grant_w;
      ISSUE:   mem_valid_w = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      owner_q     <= REQ_FETCH;
      rr_ptr_q    <= REQ_FETCH;
      cnt_q       <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_we_q    <= 1'b0;
      rsp_valid_q <= 2'b00;
      rsp_err_q   <= 2'b00;
      rsp_rdata_q <= '0;
    end else begin
      rsp_valid_q <= 2'b00;
      rsp_err_q   <= 2'b00;

      if (accept_w) begin
        mem_addr_q  <= mem_addr_d;
        mem_wdata_q <= mem_wdata_d;
        mem_we_q    <= mem_we_d;
        owner_q     <= winner_w;
        rr_ptr_q    <= ~winner_w;
      end

      // Saturate rather than wrap so a disabled timeout can never fire.
      if (handshake_w) begin
        cnt_q <= '0;
      end else if ((state_q == WAIT) && (cnt_q != CNT_MAX)) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end

      if (rsp_ok_w) begin
        rsp_valid_q[owner_q] <= 1'b1;
        rsp_rdata_q[owner_q] <= bus.mem_rdata;
      end else if (timeout_w) begin
        rsp_valid_q[owner_q] <= 1'b1;
        rsp_err_q[owner_q]   <= 1'b1;
        rsp_rdata_q[owner_q] <= '0;
      end
    end
  end

  assign bus.req0_ready = ready_w[0];
  assign bus.req1_ready = ready_w[1];

  assign bus.rsp0_valid = rsp_valid_q[0];
  assign bus.rsp0_err   = rsp_err_q[0];
  assign bus.rsp0_rdata = rsp_rdata_q[0];
  assign bus.rsp1_valid = rsp_valid_q[1];
  assign bus.rsp1_err   = rsp_err_q[1];
  assign bus.rsp1_rdata = rsp_rdata_q[1];

  assign bus.mem_valid  = mem_valid_w;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_wdata  = mem_wdata_q;
  assign bus.mem_we     = mem_we_q;
  assign bus.owner      = owner_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_port_arbiter
// Purpose  : Directed and randomized self-checking bench for mem_port_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;
  import cpu_bus_pkg::*;

  localparam int DW = 32;
  localparam int AW = 32;
  localparam int TO = 15;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  mem_port_arbiter #(.DATA_W(DW), .ADDR_W(AW), .TIMEOUT(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;

  // Requester stimulus
  logic          r_valid [2];
  logic [AW-1:0] r_addr  [2];
  logic [DW-1:0] r_wdata [2];
  logic          r_we    [2];
  logic          keep    [2];
  bit            rnd_mode;
  bit            noise;

  // Memory behaviour knobs
  int            cfg_ready_wait;
  int            cfg_rvalid_at;
  logic [DW-1:0] cfg_rdata;

  // Transaction-level reference model
  bit            m_busy, m_hs;
  int            m_issue_n, m_wait_n, rsp_count;
  req_id_t       m_ptr, m_owner;
  logic [AW-1:0] t_addr;
  logic [DW-1:0] t_wdata;
  logic          t_we;
  logic [1:0]    m_pulse;
  logic          m_err;
  logic [DW-1:0] m_last [2];

  // Values sampled from the DUT in the latest cycle
  logic [1:0]    s_ready, s_rsp_valid, s_err;
  logic          s_mem_valid, s_mem_we;
  req_id_t       s_owner;
  logic [AW-1:0] s_mem_addr;
  logic [DW-1:0] s_mem_wdata;
  logic [DW-1:0] s_rdata [2];
  int            dut_grants [$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_hs = 0; m_issue_n = 0; m_wait_n = 0;
    m_ptr = REQ_FETCH; m_owner = REQ_FETCH;
    m_pulse = 2'b00; m_err = 1'b0;
    m_last[0] = '0; m_last[1] = '0;
  endtask

  task automatic new_req(input int n);
    r_valid[n] = 1'b1;
    r_addr[n]  = $urandom;
    r_wdata[n] = $urandom;
    r_we[n]    = 1'($urandom_range(0, 1));
  endtask

  task automatic drive_inputs();
    bus.req0_valid = r_valid[0]; bus.req0_addr = r_addr[0];
    bus.req0_wdata = r_wdata[0]; bus.req0_we   = r_we[0];
    bus.req1_valid = r_valid[1]; bus.req1_addr = r_addr[1];
    bus.req1_wdata = r_wdata[1]; bus.req1_we   = r_we[1];
    bus.mem_ready  = 1'b0;
    bus.mem_rvalid = 1'b0;
    if (m_busy && !m_hs) begin
      bus.mem_ready  = (m_issue_n >= cfg_ready_wait);
      bus.mem_rvalid = noise && ($urandom_range(0, 1) == 1);
    end else if (m_busy) begin
      bus.mem_ready  = noise && ($urandom_range(0, 1) == 1);
      bus.mem_rvalid = (cfg_rvalid_at != 0) && (m_wait_n + 1 == cfg_rvalid_at);
    end
    bus.mem_rdata = rnd_mode ? DW'($urandom) : cfg_rdata;
  endtask

  task automatic finish_txn(input logic err, input logic [DW-1:0] data);
    m_pulse          = (m_owner == REQ_DATA) ? 2'b10 : 2'b01;
    m_err            = err;
    m_last[m_owner]  = err ? '0 : data;
    m_busy           = 0;
    m_hs             = 0;
    rsp_count++;
  endtask

  // One clock: check at the falling edge, then advance the model past the rising edge.
  task automatic cycle();
    logic [1:0]    v, er;
    req_id_t       win;
    logic          hs, rv;
    logic [DW-1:0] rd;
    @(negedge clk);
    v   = {bus.req1_valid, bus.req0_valid};
    win = (v == 2'b11) ? m_ptr : req_id_t'(v[1]);
    er  = (!m_busy && v != 2'b00) ? ((win == REQ_DATA) ? 2'b10 : 2'b01) : 2'b00;
    s_ready     = {bus.req1_ready, bus.req0_ready};
    s_rsp_valid = {bus.rsp1_valid, bus.rsp0_valid};
    s_err       = {bus.rsp1_err, bus.rsp0_err};
    s_mem_valid = bus.mem_valid;
    s_mem_addr  = bus.mem_addr;
    s_mem_wdata = bus.mem_wdata;
    s_mem_we    = bus.mem_we;
    s_owner     = bus.owner;
    s_rdata[0]  = bus.rsp0_rdata;
    s_rdata[1]  = bus.rsp1_rdata;
    if (!rst) begin
      chk("req_ready", 64'(s_ready), 64'(er));
      chk("mem_valid", 64'(s_mem_valid), 64'(m_busy && !m_hs));
      chk("owner", 64'(s_owner), 64'(m_owner));
      if (m_busy && !m_hs) begin
        chk("mem_addr", 64'(s_mem_addr), 64'(t_addr));
        chk("mem_wdata", 64'(s_mem_wdata), 64'(t_wdata));
        chk("mem_we", 64'(s_mem_we), 64'(t_we));
      end
      chk("rsp_valid", 64'(s_rsp_valid), 64'(m_pulse));
      if (m_pulse != 2'b00) chk("rsp_err", 64'(s_err[m_owner]), 64'(m_err));
      chk("rsp0_rdata", 64'(s_rdata[0]), 64'(m_last[0]));
      chk("rsp1_rdata", 64'(s_rdata[1]), 64'(m_last[1]));
      if (s_ready != 2'b00) dut_grants.push_back(s_ready[1] ? 1 : 0);
    end
    hs = m_busy && !m_hs && bus.mem_ready;
    rv = m_busy && m_hs && bus.mem_rvalid;
    rd = bus.mem_rdata;
    @(posedge clk);
    #1;
    if (rst) begin
      model_reset();
    end else begin
      m_pulse = 2'b00;
      if (m_busy && m_hs) begin
        m_wait_n++;
        if (rv)                           finish_txn(1'b0, rd);
        else if (TO != 0 && m_wait_n == TO) finish_txn(1'b1, '0);
      end else if (m_busy) begin
        if (hs) begin m_hs = 1; m_wait_n = 0; end
        else m_issue_n++;
      end else if (er != 2'b00) begin
        m_busy = 1; m_hs = 0; m_issue_n = 0;
        t_addr = r_addr[win]; t_wdata = r_wdata[win]; t_we = r_we[win];
        m_owner = win;
        m_ptr   = ~win;
        if (rnd_mode) begin
          cfg_ready_wait = $urandom_range(0, 3);
          cfg_rvalid_at  = $urandom_range(0, 18);
        end
        if (keep[win]) new_req(int'(win));
        else           r_valid[win] = 1'b0;
      end
    end
    if (rnd_mode) begin
      for (int n = 0; n < 2; n++)
        if (!r_valid[n] && $urandom_range(0, 2) == 0) new_req(n);
    end
    drive_inputs();
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    r_valid[0] = 1'b0; r_valid[1] = 1'b0;
    drive_inputs();
    cycle();
    cycle();
    rst = 1'b0;
    drive_inputs();
  endtask

  task automatic wait_rsp(input int budget, output int n);
    n = 0;
    do begin
      cycle();
      n++;
    end while (s_rsp_valid == 2'b00 && n < budget);
    chk("rsp_arrives", 64'(s_rsp_valid != 2'b00), 64'd1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((m_busy || r_valid[0] || r_valid[1]) && n < 400) begin
      cycle();
      n++;
    end
    chk("drain_bound", 64'(n < 400), 64'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [AW-1:0] a_sv;
    logic [DW-1:0] w_sv;
    logic          we_sv;

    rnd_mode = 0; noise = 0;
    keep[0] = 1'b0; keep[1] = 1'b0;
    for (int i = 0; i < 2; i++) begin
      r_valid[i] = 1'b0; r_addr[i] = '0; r_wdata[i] = '0; r_we[i] = 1'b0;
    end
    cfg_ready_wait = 0; cfg_rvalid_at = 1; cfg_rdata = '0;
    rsp_count = 0;
    model_reset();

    // Reset state
    apply_reset();
    cycle();
    chk("rst_mem_valid", 64'(s_mem_valid), 64'd0);
    chk("rst_mem_addr", 64'(s_mem_addr), 64'd0);
    chk("rst_mem_wdata", 64'(s_mem_wdata), 64'd0);
    chk("rst_mem_we", 64'(s_mem_we), 64'd0);
    chk("rst_owner", 64'(s_owner), 64'd0);
    chk("rst_rsp", 64'({s_rsp_valid, s_err}), 64'd0);

    // Single read, best-case latency
    cfg_ready_wait = 0; cfg_rvalid_at = 1; cfg_rdata = 32'hDEAD_BEEF;
    r_valid[0] = 1'b1; r_addr[0] = 32'h0000_0040; r_wdata[0] = '0; r_we[0] = 1'b0;
    drive_inputs();
    cycle();
    chk("lat_T_ready", 64'(s_ready), 64'b01);
    cycle();
    chk("lat_T1_mem_valid", 64'(s_mem_valid), 64'd1);
    chk("lat_T1_mem_addr", 64'(s_mem_addr), 64'h40);
    cycle();
    chk("lat_T2_no_rsp", 64'(s_rsp_valid), 64'd0);
    cycle();
    chk("lat_T3_rsp_valid", 64'(s_rsp_valid), 64'b01);
    chk("lat_T3_rdata", 64'(s_rdata[0]), 64'hDEAD_BEEF);
    chk("lat_T3_err", 64'(s_err[0]), 64'd0);

    // Both requesters continuously valid: grants alternate from fetch
    apply_reset();
    cfg_ready_wait = 1; cfg_rvalid_at = 2; cfg_rdata = 32'h0BAD_F00D;
    keep[0] = 1'b1; keep[1] = 1'b1;
    new_req(0); new_req(1);
    drive_inputs();
    dut_grants.delete();
    n = rsp_count;
    for (int c = 0; c < 200 && rsp_count - n < 4; c++) cycle();
    keep[0] = 1'b0; keep[1] = 1'b0;
    drain();
    chk("alt_grant_count", 64'(dut_grants.size() >= 4), 64'd1);
    for (int i = 0; i < 4 && i < dut_grants.size(); i++)
      chk("alt_grant_order", 64'(dut_grants[i]), 64'(i % 2));

    // Memory stalls for 5 cycles; request must hold steady
    noise = 1; cfg_ready_wait = 5; cfg_rvalid_at = 3;
    new_req(0);
    a_sv = r_addr[0]; w_sv = r_wdata[0]; we_sv = r_we[0];
    drive_inputs();
    cycle();
    new_req(1);
    drive_inputs();
    for (int i = 0; i < 5; i++) begin
      cycle();
      chk("stall_mem_valid", 64'(s_mem_valid), 64'd1);
      chk("stall_mem_addr", 64'(s_mem_addr), 64'(a_sv));
      chk("stall_mem_wdata", 64'(s_mem_wdata), 64'(w_sv));
      chk("stall_mem_we", 64'(s_mem_we), 64'(we_sv));
      chk("stall_no_ready", 64'(s_ready), 64'd0);
    end
    drain();
    noise = 0;

    // Write from the data requester
    cfg_ready_wait = 0; cfg_rvalid_at = 1; cfg_rdata = 32'h5555_AAAA;
    r_valid[1] = 1'b1; r_addr[1] = 32'h100; r_wdata[1] = 32'h1234_5678; r_we[1] = 1'b1;
    drive_inputs();
    cycle();
    cycle();
    chk("wr_mem_we", 64'(s_mem_we), 64'd1);
    chk("wr_mem_wdata", 64'(s_mem_wdata), 64'h1234_5678);
    chk("wr_mem_addr", 64'(s_mem_addr), 64'h100);
    chk("wr_owner", 64'(s_owner), 64'd1);
    wait_rsp(20, n);
    chk("wr_rsp1_valid", 64'(s_rsp_valid), 64'b10);

    // Memory never answers: error after exactly TO wait cycles
    cfg_rvalid_at = 0; cfg_rdata = 32'hCAFE_F00D;
    r_valid[0] = 1'b1; r_addr[0] = 32'h200; r_we[0] = 1'b0;
    drive_inputs();
    cycle();
    chk("to_ready", 64'(s_ready), 64'b01);
    wait_rsp(40, n);
    chk("to_cycles", 64'(n), 64'(TO + 2));
    chk("to_rsp_valid", 64'(s_rsp_valid), 64'b01);
    chk("to_err", 64'(s_err[0]), 64'd1);
    chk("to_rdata", 64'(s_rdata[0]), 64'd0);

    // Response on the last allowed wait cycle is a normal completion
    cfg_rvalid_at = TO;
    r_valid[1] = 1'b1; r_addr[1] = 32'h300; r_we[1] = 1'b0;
    drive_inputs();
    cycle();
    wait_rsp(40, n);
    chk("late_cycles", 64'(n), 64'(TO + 2));
    chk("late_rsp_valid", 64'(s_rsp_valid), 64'b10);
    chk("late_err", 64'(s_err[1]), 64'd0);
    chk("late_rdata", 64'(s_rdata[1]), 64'hCAFE_F00D);

    // Reset while waiting on memory
    cfg_rvalid_at = 0;
    r_valid[0] = 1'b1; r_addr[0] = 32'h400; r_wdata[0] = 32'h77; r_we[0] = 1'b1;
    drive_inputs();
    for (int i = 0; i < 4; i++) cycle();
    rst = 1'b1;
    r_valid[0] = 1'b0; r_valid[1] = 1'b0;
    drive_inputs();
    cycle();
    rst = 1'b0;
    new_req(0); new_req(1);
    drive_inputs();
    cycle();
    chk("mid_rst_mem_valid", 64'(s_mem_valid), 64'd0);
    chk("mid_rst_mem_addr", 64'(s_mem_addr), 64'd0);
    chk("mid_rst_mem_wdata", 64'(s_mem_wdata), 64'd0);
    chk("mid_rst_mem_we", 64'(s_mem_we), 64'd0);
    chk("mid_rst_owner", 64'(s_owner), 64'd0);
    chk("mid_rst_rsp", 64'({s_rsp_valid, s_err}), 64'd0);
    chk("mid_rst_rdata", 64'({s_rdata[1], s_rdata[0]}), 64'd0);
    chk("mid_rst_grant", 64'(s_ready), 64'b01);
    cfg_rvalid_at = 2;
    drain();

    // Randomized traffic against the model
    rnd_mode = 1; noise = 1;
    for (int c = 0; c < 3000; c++) cycle();
    rnd_mode = 0;
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the CPU's single 32-bit memory port between two requesters: requester 0 is instruction fetch, requester 1 is data load/store.
- Picks one requester at a time with round-robin priority. It latches that request and drives it onto the port through the 2:1 select path.
- It then waits for the memory response and routes it back to the owner.
- A timeout counter turns a hung memory into an error response instead of a deadlocked core.

Parameters:
DATA_W, 32, data width of requests, responses and memory port
ADDR_W, 32, address width
TIMEOUT, 15, max cycles in WAIT without mem_rvalid before an error response; 0 disables the timeout

Ports:
clk  in  1  system clock, rising-edge
rst  in  1  synchronous, active-high reset
req0_valid  in  1  requester 0 (fetch) has a request
req0_addr  in  ADDR_W  requester 0 address
req0_wdata  in  DATA_W  requester 0 write data
req0_we  in  1  requester 0 write enable
req0_ready  out  1  requester 0 request accepted this cycle
rsp0_valid  out  1  response to requester 0, one-cycle pulse
rsp0_rdata  out  DATA_W  read data to requester 0
rsp0_err  out  1  requester 0 response is a timeout error
req1_valid, req1_addr, req1_wdata, req1_we, req1_ready, rsp1_valid, rsp1_rdata, rsp1_err  same as above, for requester 1 (data)
mem_valid  out  1  request to memory valid
mem_addr  out  ADDR_W  latched request address
mem_wdata  out  DATA_W  latched write data
mem_we  out  1  latched write enable
mem_ready  in  1  memory accepts request (handshake = mem_valid & mem_ready)
mem_rvalid  in  1  memory response valid; acknowledges writes too
mem_rdata  in  DATA_W  memory read data
owner  out  1  current port owner, 0 or 1; drives the datapath mux select

Behaviour:
- Clocking and reset:
  - One clock domain.
  - All state is registered on the rising edge of clk.
  - rst is synchronous and active-high.
- Reset values:
  - state=IDLE, owner=0, rr_ptr=0 (requester 0 has priority), timeout counter=0.
  - mem_valid, mem_we, all reqN_ready, rspN_valid and rspN_err = 0.
  - mem_addr, mem_wdata and all rspN_rdata = 0.
- State machine: states IDLE, ISSUE, WAIT.
- IDLE:
  - If neither request is valid, stay in IDLE.
  - If exactly one request is valid, grant it.
  - If both are valid, grant the requester selected by rr_ptr.
  - reqN_ready is asserted combinationally for the winner only; acceptance is reqN_valid & reqN_ready.
  - On accept: latch addr/wdata/we into the mem_* registers, set owner=N, set rr_ptr=~N, go to ISSUE.
- ISSUE:
  - mem_valid=1, held stable until mem_ready=1.
  - On handshake: clear the timeout counter and go to WAIT.
  - mem_rvalid in ISSUE is ignored.
- WAIT:
  - mem_valid=0; the counter increments each cycle.
  - On mem_rvalid: next cycle rsp[owner]_valid=1, rsp[owner]_rdata=mem_rdata, rsp[owner]_err=0; go to IDLE.
  - If TIMEOUT≠0 and the counter reaches TIMEOUT-1 without mem_rvalid: next cycle rsp[owner]_valid=1, rsp[owner]_err=1, rsp[owner]_rdata=0; go to IDLE.
  - If mem_rvalid arrives in the same cycle as the timeout, mem_rvalid wins and the response is normal.
- Responses:
  - rspN_valid is a registered pulse of exactly one cycle.
  - rdata is held until the next response to that requester.
  - The non-owner's rsp outputs never pulse.
- Latency, best case:
  - Accept at cycle T.
  - mem_valid at T+1; mem_ready at T+1.
  - mem_rvalid at T+2.
  - rsp pulse at T+3.
  - Earliest next accept is T+3: the return to IDLE and the response pulse land in the same cycle.
- Outstanding requests: at most one transaction at a time; both reqN_ready stay 0 outside IDLE.
- owner: changes only on accept; stable through ISSUE and WAIT.
- Counter width: $clog2(TIMEOUT+1), minimum 1; it never wraps.
- Reset mid-operation: the outstanding transaction is dropped with no response, mem_valid drops on the next edge, and rr_ptr returns to 0.

Decomposition:
- Package cpu_bus_pkg:
  - arb_state_t enum {IDLE, ISSUE, WAIT}
  - req_id_t (1-bit) with constants REQ_FETCH=0 and REQ_DATA=1
  - default DATA_W and ADDR_W constants
- Sub-module rr_arbiter2 (combinational): inputs valid[1:0] and rr_ptr; outputs grant[1:0] (one-hot or zero) and winner id.
- rr_ptr update and the FSM stay in mem_port_arbiter.

Test Plan:
- Reset, then a single read: req0_valid=1, addr=0x0000_0040; memory ready immediately and rvalid after 1 cycle with rdata=0xDEAD_BEEF -> req0_ready at T, mem_addr=0x40 with mem_valid at T+1, rsp0_valid pulse at T+3 with rdata=0xDEAD_BEEF and err=0; rsp1 never pulses.
- Both requesters valid continuously from reset -> grants alternate 0,1,0,1 across 4 transactions; owner matches each grant; each response goes only to its owner.
- mem_ready held low for 5 cycles -> mem_valid, mem_addr, mem_we and mem_wdata stay stable for all 5 cycles; no reqN_ready during that time; normal completion afterwards.
- Write from requester 1 (we=1, addr=0x100, wdata=0x1234_5678) -> mem_we=1 and mem_wdata=0x1234_5678 during ISSUE; rsp1_valid pulses after mem_rvalid.
- Timeout with TIMEOUT=15 and mem_rvalid never asserted -> exactly 15 WAIT cycles, then rsp_err=1, rdata=0 and valid pulse; return to IDLE. Repeat with rvalid on the 15th WAIT cycle -> normal response, err=0.
- rst asserted during WAIT -> all outputs at reset values next cycle; no response pulse; the following request with both valid is granted to requester 0.
